// File: rtl/fifo_read_port.sv
// Read-domain controller for a dual-clock FIFO with a first-word-fall-through output.
// Optional: define FIFO_RD_LEVEL_EN to add the registered rlevel occupancy output.
module fifo_read_port #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr_gray,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic                rempty,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
`ifdef FIFO_RD_LEVEL_EN
    output logic [ADDRSIZE:0]   rlevel,
`endif
    input  logic                rready
);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] rq1;
    logic [ADDRSIZE:0] rq2;
    logic              pop;

    // Read the memory whenever a word is available and the output slot is free
    // or being emptied this cycle; this keeps one word per cycle sustained.
    assign pop        = !rempty && (!rvalid || rready);
    assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, pop};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign raddr      = rbin[ADDRSIZE-1:0];

    // Two-flop synchronizer for the write pointer; Gray code keeps it single-bit-change.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= wptr_gray;
            rq2 <= rq1;
        end
    end

    // Read pointer and empty flag; the compare includes the wrap MSB.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == rq2);
        end
    end

    // Output register: load on pop, drop valid when consumed with nothing behind it.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (pop) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Words still in memory, excluding the output register; lags writes by the sync delay.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel <= '0;
        end else begin
            rlevel <= gray2bin(rq2) - rbin_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed self-checking bench for fifo_read_port with a behavioural memory
// and write pointer driven from the bench.
module tb_fifo_read_port;

    logic       rclk;
    logic       rrst;
    logic [4:0] wptr_gray;
    logic [7:0] mem_rdata;
    logic [3:0] raddr;
    logic [4:0] rptr_gray;
    logic       rempty;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] rlevel;
`endif

    logic [7:0] mem [16];
    logic [4:0] wbin;

    int passes;
    int total;

    assign wptr_gray = wbin ^ (wbin >> 1);
    assign mem_rdata = mem[raddr];

    fifo_read_port #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .wptr_gray (wptr_gray),
        .mem_rdata (mem_rdata),
        .raddr     (raddr),
        .rptr_gray (rptr_gray),
        .rempty    (rempty),
        .rdata     (rdata),
        .rvalid    (rvalid),
`ifdef FIFO_RD_LEVEL_EN
        .rlevel    (rlevel),
`endif
        .rready    (rready)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rrst   = 1'b1;
        rready = 1'b1;
        wbin   = 5'd0;
        step();
        step();
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rempty", 32'(rempty), 32'h1);
        rrst = 1'b0;

        // idle with nothing written
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_rempty", 32'(rempty), 32'h1);
            check("idle_rvalid", 32'(rvalid), 32'h0);
            check("idle_raddr", 32'(raddr), 32'h0);
            check("idle_rptr", 32'(rptr_gray), 32'h0);
        end

        // single word, consumer stalled
        mem[0] = 8'hA5;
        wbin   = 5'd1;
        rready = 1'b0;
        step();
        check("one_e1_rempty", 32'(rempty), 32'h1);
        step();
        check("one_e2_rempty", 32'(rempty), 32'h1);
        step();
        check("one_e3_rempty", 32'(rempty), 32'h0);
        check("one_e3_rvalid", 32'(rvalid), 32'h0);
        step();
        check("one_e4_rvalid", 32'(rvalid), 32'h1);
        check("one_e4_rdata", 32'(rdata), 32'hA5);
        check("one_e4_rempty", 32'(rempty), 32'h1);
        check("one_e4_rptr", 32'(rptr_gray), 32'h1);
        check("one_e4_raddr", 32'(raddr), 32'h1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("one_hold_rvalid", 32'(rvalid), 32'h1);
            check("one_hold_rdata", 32'(rdata), 32'hA5);
        end
        rready = 1'b1;
        step();
        check("one_take_rvalid", 32'(rvalid), 32'h0);
        rready = 1'b0;

        // reset both domains
        rrst = 1'b1;
        wbin = 5'd0;
        step();
        rrst = 1'b0;
        check("rst2_rvalid", 32'(rvalid), 32'h0);
        check("rst2_rptr", 32'(rptr_gray), 32'h0);

        // full memory, streamed at one word per cycle
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + 3 * i);
        wbin   = 5'd16;
        rready = 1'b1;
        step();
        step();
        step();
        check("full_e3_rempty", 32'(rempty), 32'h0);
        check("full_e3_rvalid", 32'(rvalid), 32'h0);
        for (int k = 0; k < 16; k++) begin
            step();
            check("full_rvalid", 32'(rvalid), 32'h1);
            check("full_rdata", 32'(rdata), 32'(8'(8'h10 + 3 * k)));
        end
        check("full_end_rempty", 32'(rempty), 32'h1);
        check("full_end_rptr", 32'(rptr_gray), 32'h18);
        check("full_end_raddr", 32'(raddr), 32'h0);
        step();
        check("full_drain_rvalid", 32'(rvalid), 32'h0);

        // wrap into the second pass
        mem[0] = 8'hC0;
        mem[1] = 8'hC1;
        mem[2] = 8'hC2;
        wbin   = 5'd19;
        step();
        step();
        step();
        check("wrap_e3_rempty", 32'(rempty), 32'h0);
        check("wrap_e3_raddr", 32'(raddr), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("wrap_rvalid", 32'(rvalid), 32'h1);
            check("wrap_rdata", 32'(rdata), 32'(8'hC0 + k));
            check("wrap_raddr", 32'(raddr), 32'(k + 1));
        end
        check("wrap_rempty", 32'(rempty), 32'h1);
        check("wrap_rptr", 32'(rptr_gray), 32'h1A);
        step();
        check("wrap_drain_rvalid", 32'(rvalid), 32'h0);

        // backpressure with rready toggling
        mem[3] = 8'hD0;
        mem[4] = 8'hD1;
        mem[5] = 8'hD2;
        mem[6] = 8'hD3;
        wbin   = 5'd23;
        rready = 1'b0;
        step();
        step();
        step();
        check("bp_e3_rempty", 32'(rempty), 32'h0);
`ifdef FIFO_RD_LEVEL_EN
        check("bp_e3_rlevel", 32'(rlevel), 32'h4);
`endif
        step();
        check("bp_e4_rvalid", 32'(rvalid), 32'h1);
        check("bp_e4_rdata", 32'(rdata), 32'hD0);
        check("bp_e4_raddr", 32'(raddr), 32'h4);
`ifdef FIFO_RD_LEVEL_EN
        check("bp_e4_rlevel", 32'(rlevel), 32'h3);
`endif
        rready = 1'b1;
        step();
        check("bp_t1_rdata", 32'(rdata), 32'hD1);
        check("bp_t1_raddr", 32'(raddr), 32'h5);
        rready = 1'b0;
        step();
        check("bp_t2_rvalid", 32'(rvalid), 32'h1);
        check("bp_t2_rdata", 32'(rdata), 32'hD1);
        check("bp_t2_raddr", 32'(raddr), 32'h5);
        rready = 1'b1;
        step();
        check("bp_t3_rdata", 32'(rdata), 32'hD2);
        check("bp_t3_raddr", 32'(raddr), 32'h6);
        rready = 1'b0;
        step();
        check("bp_t4_rdata", 32'(rdata), 32'hD2);
        check("bp_t4_raddr", 32'(raddr), 32'h6);
        rready = 1'b1;
        step();
        check("bp_t5_rvalid", 32'(rvalid), 32'h1);
        check("bp_t5_rdata", 32'(rdata), 32'hD3);
        check("bp_t5_raddr", 32'(raddr), 32'h7);
        check("bp_t5_rempty", 32'(rempty), 32'h1);
        step();
        check("bp_t6_rvalid", 32'(rvalid), 32'h0);

        // reset while a word is held and more are pending
        mem[7]  = 8'hE0;
        mem[8]  = 8'hE1;
        mem[9]  = 8'hE2;
        mem[10] = 8'hE3;
        wbin    = 5'd27;
        rready  = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("mid_rvalid", 32'(rvalid), 32'h1);
        check("mid_rdata", 32'(rdata), 32'hE0);
        check("mid_rempty", 32'(rempty), 32'h0);
        rrst = 1'b1;
        wbin = 5'd0;
        step();
        rrst = 1'b0;
        check("mrst_rvalid", 32'(rvalid), 32'h0);
        check("mrst_rempty", 32'(rempty), 32'h1);
        check("mrst_raddr", 32'(raddr), 32'h0);
        check("mrst_rptr", 32'(rptr_gray), 32'h0);
        check("mrst_rq2", 32'(dut.rq2), 32'h0);
`ifdef FIFO_RD_LEVEL_EN
        check("mrst_rlevel", 32'(rlevel), 32'h0);
`endif
        mem[0] = 8'hF0;
        mem[1] = 8'hF1;
        mem[2] = 8'hF2;
        mem[3] = 8'hF3;
        wbin   = 5'd4;
        step();
        step();
        step();
        check("post_e3_rempty", 32'(rempty), 32'h0);
        check("post_e3_rvalid", 32'(rvalid), 32'h0);
`ifdef FIFO_RD_LEVEL_EN
        check("post_e3_rlevel", 32'(rlevel), 32'h4);
`endif
        step();
        check("post_e4_rvalid", 32'(rvalid), 32'h1);
        check("post_e4_rdata", 32'(rdata), 32'hF0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
